i2c_instr_sequencer: RTL and testbench

Program sequencer that sits directly downstream of the instruction register memory. It walks the memory address space, fetches 32-bit instruction words (op | dev | reg | data, 8 bits each), and decodes them. It issues I2C read/write commands to the I2C master through a valid/ready handshake and forwards read results toward the display path. The block stops on program end, memory error, NACK or response timeout.

---
 rtl/i2c_instr_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_i2c_instr_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_instr_sequencer.sv
// rtl/i2c_instr_sequencer.sv - walks instruction memory, decodes op|dev|reg|data words and
// drives I2C read/write commands; stops on END, last address, memory error, NACK or timeout.
module i2c_instr_sequencer #(
  parameter int ADDR_W         = 8,
  parameter int LAST_ADDR      = 255,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] reg_addr,
  input  logic [31:0]       read_data,
  input  logic [3:0]        error_code,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_rw,
  output logic [7:0]        cmd_dev,
  output logic [7:0]        cmd_reg,
  output logic [7:0]        cmd_wdata,
  input  logic              rsp_valid,
  input  logic              rsp_nack,
  input  logic [7:0]        rsp_rdata,
  output logic              rd_data_valid,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [3:0]        fault_code
);

  localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(LAST_ADDR);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_END   = 8'h03;

  localparam logic [3:0] FC_MEM     = 4'd1;
  localparam logic [3:0] FC_ILLEGAL = 4'd2;
  localparam logic [3:0] FC_NACK    = 4'd3;
  localparam logic [3:0] FC_TIMEOUT = 4'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT_RSP,
    S_DONE,
    S_FAULT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [7:0]       op;
  logic             at_last;

  // reg_addr doubles as the program counter, so a fault leaves it on the offending word
  assign op      = read_data[31:24];
  assign at_last = (reg_addr == LAST_PC);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      reg_addr      <= '0;
      cmd_valid     <= 1'b0;
      cmd_rw        <= 1'b0;
      cmd_dev       <= 8'h00;
      cmd_reg       <= 8'h00;
      cmd_wdata     <= 8'h00;
      rd_data_valid <= 1'b0;
      rd_data       <= 8'h00;
      busy          <= 1'b0;
      done          <= 1'b0;
      fault         <= 1'b0;
      fault_code    <= 4'd0;
    end else begin
      done          <= 1'b0;
      rd_data_valid <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_FAULT: begin
          if (start) begin
            reg_addr   <= '0;
            fault      <= 1'b0;
            fault_code <= 4'd0;
            busy       <= 1'b1;
            state      <= S_FETCH;
          end else if (state == S_DONE) begin
            state <= S_IDLE;
          end
        end
        S_FETCH: begin
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (error_code != 4'd0) begin
            fault      <= 1'b1;
            fault_code <= FC_MEM;
            busy       <= 1'b0;
            state      <= S_FAULT;
          end else begin
            case (op)
              OP_NOP: begin
                if (at_last) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_DONE;
                end else begin
                  reg_addr <= reg_addr + ADDR_W'(1);
                  state    <= S_FETCH;
                end
              end
              OP_READ, OP_WRITE: begin
                cmd_rw    <= (op == OP_READ);
                cmd_dev   <= read_data[23:16];
                cmd_reg   <= read_data[15:8];
                cmd_wdata <= read_data[7:0];
                cmd_valid <= 1'b1;
                state     <= S_ISSUE;
              end
              OP_END: begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_DONE;
              end
              default: begin
                fault      <= 1'b1;
                fault_code <= FC_ILLEGAL;
                busy       <= 1'b0;
                state      <= S_FAULT;
              end
            endcase
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            wait_cnt  <= '0;
            state     <= S_WAIT_RSP;
          end
        end
        S_WAIT_RSP: begin
          if (rsp_valid) begin
            if (rsp_nack) begin
              fault      <= 1'b1;
              fault_code <= FC_NACK;
              busy       <= 1'b0;
              state      <= S_FAULT;
            end else begin
              if (cmd_rw) begin
                rd_data       <= rsp_rdata;
                rd_data_valid <= 1'b1;
              end
              if (at_last) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_DONE;
              end else begin
                reg_addr <= reg_addr + ADDR_W'(1);
                state    <= S_FETCH;
              end
            end
          end else if (wait_cnt == CNT_MAX) begin
            // counter already sat at the limit for one full cycle: give up
            fault      <= 1'b1;
            fault_code <= FC_TIMEOUT;
            busy       <= 1'b0;
            state      <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_instr_sequencer.sv
// tb/tb_i2c_instr_sequencer.sv - table-driven scoreboard bench for i2c_instr_sequencer
module tb_i2c_instr_sequencer;

  localparam int TMO  = 8;
  localparam int LAST = 3;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  reg_addr;
  logic [31:0] read_data;
  logic [3:0]  error_code;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [7:0]  cmd_dev;
  logic [7:0]  cmd_reg;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic        rsp_nack;
  logic [7:0]  rsp_rdata;
  logic        rd_data_valid;
  logic [7:0]  rd_data;
  logic        busy;
  logic        done;
  logic        fault;
  logic [3:0]  fault_code;

  i2c_instr_sequencer #(
    .ADDR_W(8), .LAST_ADDR(LAST), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .reg_addr(reg_addr),
    .read_data(read_data), .error_code(error_code), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_rw(cmd_rw), .cmd_dev(cmd_dev), .cmd_reg(cmd_reg),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_nack(rsp_nack),
    .rsp_rdata(rsp_rdata), .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .busy(busy), .done(done), .fault(fault), .fault_code(fault_code)
  );

  typedef struct packed {
    logic       rw;
    logic [7:0] dev;
    logic [7:0] rg;
    logic [7:0] wd;
  } cmd_t;

  typedef struct {
    logic [3:0][31:0] prog;
    int               err_addr;
    int               ready_dly;
    int               rsp_dly;
    bit               nack;
    bit               no_rsp;
    logic [7:0]       rdata;
    bit               exp_done;
    logic [3:0]       exp_code;
    logic [7:0]       exp_addr;
  } vec_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         hs_count = 0;
  int         accept_cyc = 0;
  logic [31:0] mem [256];
  int         err_addr = 1000;
  int         cur_ready_dly = 0;
  int         cur_rsp_dly = 0;
  bit         cur_nack = 0;
  bit         cur_no_rsp = 0;
  logic [7:0] cur_rdata = 8'h00;
  bit         inject_rsp = 0;
  cmd_t       cmd_q [$];
  logic [7:0] rd_q [$];
  vec_t       vecs [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // instruction memory: registered read, error sticky from err_addr upward
  always @(posedge clk) begin
    read_data  <= mem[reg_addr];
    error_code <= (int'(reg_addr) >= err_addr) ? 4'd1 : 4'd0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // I2C master model
  initial begin
    int rs, wcnt, rcnt;
    rs = 0; wcnt = 0; rcnt = 0;
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
      if (inject_rsp) begin
        rsp_valid = 1'b1;
        rsp_rdata = 8'hEE;
      end
      if (!reset_n || !busy) begin
        rs = 0; wcnt = 0; cmd_ready = 1'b0;
      end else begin
        case (rs)
          0: if (cmd_valid) begin
               if (wcnt == cur_ready_dly) begin cmd_ready = 1'b1; rs = 1; end
               else wcnt++;
             end
          1: begin cmd_ready = 1'b0; wcnt = 0; rcnt = 0; rs = 2; end
          default: if (!cur_no_rsp) begin
               if (rcnt == cur_rsp_dly) begin
                 rsp_valid = 1'b1; rsp_nack = cur_nack; rsp_rdata = cur_rdata; rs = 0;
               end else rcnt++;
             end
        endcase
      end
    end
  end

  // output monitor / scoreboard consumer
  initial begin
    cmd_t cur, prev, exp;
    int   vcyc;
    bit   stable;
    logic prev_dv;
    vcyc = 0; stable = 1; prev_dv = 1'b0; prev = '0;
    forever begin
      @(negedge clk);
      cur = {cmd_rw, cmd_dev, cmd_reg, cmd_wdata};
      if (!reset_n) begin
        vcyc = 0; stable = 1; prev_dv = 1'b0;
      end else begin
        if (cmd_valid) begin
          if (vcyc > 0 && cur != prev) stable = 0;
          vcyc++;
          prev = cur;
          if (cmd_ready) begin
            hs_count++;
            accept_cyc = cyc + 1;
            check("cmd_valid_cycles", vcyc, cur_ready_dly + 1);
            if (vcyc > 1) check("stall_fields_stable", {31'd0, stable}, 1);
            if (cmd_q.size() == 0) begin
              n_tests++; n_fail++;
              $display("FAIL unexpected_cmd: got 0x%0h, expected no command", cur);
            end else begin
              exp = cmd_q.pop_front();
              check("cmd_fields", cur, exp);
            end
            vcyc = 0; stable = 1;
          end
        end
        if (rd_data_valid) begin
          check("rd_pulse_single", {31'd0, prev_dv}, 0);
          if (rd_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_rd: got 0x%0h, expected no read pulse", rd_data);
          end else begin
            check("rd_data", rd_data, rd_q.pop_front());
          end
        end
        prev_dv = rd_data_valid;
      end
    end
  end

  function automatic vec_t mk(input logic [31:0] w0, w1, w2, w3, input int ea, rdy, rsd,
                              input bit nk, nr, input logic [7:0] rdat,
                              input bit ed, input logic [3:0] ec, input logic [7:0] eadr);
    vec_t v;
    v.prog[0] = w0; v.prog[1] = w1; v.prog[2] = w2; v.prog[3] = w3;
    v.err_addr = ea; v.ready_dly = rdy; v.rsp_dly = rsd; v.nack = nk; v.no_rsp = nr;
    v.rdata = rdat; v.exp_done = ed; v.exp_code = ec; v.exp_addr = eadr;
    return v;
  endfunction

  task automatic load(input vec_t v);
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    for (int i = 0; i < 4; i++) mem[i] = v.prog[i];
    err_addr = v.err_addr; cur_ready_dly = v.ready_dly; cur_rsp_dly = v.rsp_dly;
    cur_nack = v.nack; cur_no_rsp = v.no_rsp; cur_rdata = v.rdata;
  endtask

  // reference walk of the program: pushes the commands and reads it should produce
  task automatic predict(input vec_t v);
    int pc;
    logic [31:0] w;
    pc = 0;
    forever begin
      if (pc >= v.err_addr) break;
      w = v.prog[pc];
      if (w[31:24] == 8'h01 || w[31:24] == 8'h02) begin
        cmd_q.push_back({w[31:24] == 8'h01, w[23:16], w[15:8], w[7:0]});
        if (v.no_rsp || v.nack) break;
        if (w[31:24] == 8'h01) rd_q.push_back(v.rdata);
      end else if (w[31:24] != 8'h00) begin
        break;
      end
      if (pc == LAST) break;
      pc++;
    end
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_end(output bit got, output bit gdone, output int fcyc);
    got = 0; gdone = 0; fcyc = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (done) begin got = 1; gdone = 1; end
      else if (fault) begin got = 1; fcyc = cyc; end
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit got, gdone;
    int fcyc;
    logic [7:0] end_addr;
    bit is_cmd;
    load(v);
    predict(v);
    is_cmd = (v.prog[0][31:24] == 8'h01) || (v.prog[0][31:24] == 8'h02);
    do_start();
    @(negedge clk);
    check("start_busy", {31'd0, busy}, 1);
    check("start_clears_fault", {27'd0, fault, fault_code}, 0);
    check("start_addr", {24'd0, reg_addr}, 0);
    if (is_cmd) begin
      @(negedge clk);
      check("cmd_valid_k2", {31'd0, cmd_valid}, 0);
      @(negedge clk);
      check("cmd_valid_k3", {31'd0, cmd_valid}, 1);
    end
    wait_end(got, gdone, fcyc);
    check("finished", {31'd0, got}, 1);
    check("outcome_done", {31'd0, gdone}, {31'd0, v.exp_done});
    check("fault_code", {28'd0, fault_code}, {28'd0, v.exp_code});
    check("end_addr", {24'd0, reg_addr}, {24'd0, v.exp_addr});
    check("busy_low", {31'd0, busy}, 0);
    if (v.no_rsp) check("timeout_latency", fcyc - accept_cyc, TMO + 1);
    end_addr = reg_addr;
    @(negedge clk);
    if (gdone) check("done_single", {31'd0, done}, 0);
    repeat (3) @(negedge clk);
    check("hold_addr", {24'd0, reg_addr}, {24'd0, end_addr});
    check("hold_fault", {31'd0, fault}, {31'd0, !gdone});
    if (v.no_rsp) begin
      inject_rsp = 1'b1;
      @(negedge clk);
      inject_rsp = 1'b0;
      repeat (2) @(negedge clk);
      check("late_rsp_ignored", {27'd0, fault, fault_code}, {27'd0, 1'b1, 4'd4});
    end
    check("cmd_q_empty", cmd_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
    cmd_q.delete();
    rd_q.delete();
  endtask

  initial begin
    bit   got, gdone;
    int   fcyc, h0;
    vec_t v;
    reset_n = 1'b0; start = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    vecs[0] = mk(32'h0100F000, 32'h021DAB32, 32'h03000000, 32'h0, 1000, 0, 0, 0, 0, 8'h5A, 1, 4'd0, 8'd2);
    vecs[1] = mk(32'h0100F000, 32'h021DAB32, 32'h03000000, 32'h0, 1000, 5, 2, 0, 0, 8'hC3, 1, 4'd0, 8'd2);
    vecs[2] = mk(32'h0100F000, 32'h021DAB32, 32'h03000000, 32'h0, 1000, 0, 0, 1, 0, 8'h5A, 0, 4'd3, 8'd0);
    vecs[3] = mk(32'h0,        32'h0,        32'h0,        32'h0, 2,    0, 0, 0, 0, 8'h00, 0, 4'd1, 8'd2);
    vecs[4] = mk(32'h07000000, 32'h0,        32'h0,        32'h0, 1000, 0, 0, 0, 0, 8'h00, 0, 4'd2, 8'd0);
    vecs[5] = mk(32'h0100F000, 32'h021DAB32, 32'h03000000, 32'h0, 1000, 0, 0, 0, 1, 8'h5A, 0, 4'd4, 8'd0);
    vecs[6] = mk(32'h0,        32'h0,        32'h0,        32'h0, 1000, 0, 0, 0, 0, 8'h00, 1, 4'd0, 8'd3);
    vecs[7] = mk(32'h02112233, 32'h01445566, 32'h0,  32'h02778899, 1000, 1, 3, 0, 0, 8'h99, 1, 4'd0, 8'd3);

    repeat (3) @(negedge clk);
    check("reset_outputs",
          {reg_addr, cmd_valid, cmd_rw, cmd_dev, cmd_reg, cmd_wdata, rd_data_valid, rd_data, busy, done, fault, fault_code},
          32'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // start pulsed during WAIT_RSP must not restart the program
    v = mk(32'h0100F000, 32'h021DAB32, 32'h03000000, 32'h0, 1000, 0, 4, 0, 0, 8'h3C, 1, 4'd0, 8'd2);
    load(v);
    predict(v);
    h0 = hs_count;
    do_start();
    for (int c = 0; c < 50 && hs_count == h0; c++) @(negedge clk);
    check("busy_start_hs", {31'd0, hs_count > h0}, 1);
    do_start();
    wait_end(got, gdone, fcyc);
    check("busy_start_done", {31'd0, gdone}, 1);
    check("busy_start_addr", {24'd0, reg_addr}, 8'd2);
    repeat (2) @(negedge clk);
    check("busy_start_cmd_q", cmd_q.size(), 0);
    check("busy_start_rd_q", rd_q.size(), 0);
    cmd_q.delete(); rd_q.delete();

    // asynchronous reset in the middle of WAIT_RSP
    v = mk(32'h0100F000, 32'h021DAB32, 32'h03000000, 32'h0, 1000, 0, 20, 0, 0, 8'h77, 1, 4'd0, 8'd2);
    load(v);
    predict(v);
    h0 = hs_count;
    do_start();
    for (int c = 0; c < 50 && hs_count == h0; c++) @(negedge clk);
    check("rst_hs_seen", {31'd0, hs_count > h0}, 1);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {reg_addr, cmd_valid, cmd_rw, cmd_dev, cmd_reg, cmd_wdata, rd_data_valid, rd_data, busy, done, fault, fault_code},
          32'h0);
    cmd_q.delete(); rd_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    h0 = hs_count;
    repeat (30) @(negedge clk);
    check("idle_after_reset", {29'd0, busy, cmd_valid, done}, 0);
    check("no_cmd_after_reset", hs_count - h0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
